// File: rtl/shared_debounce_ctrl.sv
// Debounce controller sharing one stable-time counter across NUM_INPUTS raw inputs.
// The counter is granted round-robin to inputs whose synchronized level differs from the debounced level.
module shared_debounce_ctrl #(
  parameter int unsigned NUM_INPUTS        = 4,
  parameter int unsigned CLK_PERIOD_ns     = 20,
  parameter int unsigned DEBOUNCE_TIMER_ns = 200,
  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [NUM_INPUTS-1:0] sig_i,
  output logic [NUM_INPUTS-1:0] sig_o,
  output logic [NUM_INPUTS-1:0] rise_o,
  output logic [NUM_INPUTS-1:0] fall_o,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      active_idx_o
);

  localparam int unsigned T        = DEBOUNCE_TIMER_ns / CLK_PERIOD_ns;
  localparam int unsigned CNT_W    = (T > 1) ? $clog2(T + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t state_q, state_d;

  logic [NUM_INPUTS-1:0] meta_q, sync_q;
  logic [NUM_INPUTS-1:0] sig_q, sig_d;
  logic [NUM_INPUTS-1:0] rise_q, rise_d;
  logic [NUM_INPUTS-1:0] fall_q, fall_d;
  logic                  busy_q, busy_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  target_q, target_d;

  logic [NUM_INPUTS-1:0] pending_c;
  logic                  found_c;
  logic [IDX_W-1:0]      grant_idx_c;
  logic [IDX_W-1:0]      cand_c;
  logic [IDX_W-1:0]      ptr_next_c;
  logic                  grant_c, abort_c, commit_c;

  assign pending_c  = sync_q ^ sig_q;
  assign ptr_next_c = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

  // First pending input at or after ptr, wrapping around.
  always_comb begin : rr_search
    found_c     = 1'b0;
    grant_idx_c = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      cand_c = IDX_W'((32'(ptr_q) + i) % NUM_INPUTS);
      if (!found_c && pending_c[cand_c]) begin
        found_c     = 1'b1;
        grant_idx_c = cand_c;
      end
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    grant_c  = 1'b0;
    abort_c  = 1'b0;
    commit_c = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (found_c) begin
            grant_c = 1'b1;
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (sync_q[idx_q] != target_q) begin
            abort_c = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            commit_c = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin : fsm_out
    sig_d    = sig_q;
    rise_d   = '0;
    fall_d   = '0;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    busy_d   = (state_d == COUNT);
    if (grant_c) begin
      idx_d    = grant_idx_c;
      target_d = sync_q[grant_idx_c];
      cnt_d    = '0;
    end else if (abort_c) begin
      ptr_d = ptr_next_c;
    end else if (commit_c) begin
      ptr_d        = ptr_next_c;
      sig_d[idx_q] = target_q;
      if (target_q) rise_d[idx_q] = 1'b1;
      else          fall_d[idx_q] = 1'b1;
    end else if (enable && state_q == COUNT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizers keep sampling even while the FSM is frozen.
  always_ff @(posedge clk) begin : data_reg
    if (!resetn) begin
      meta_q   <= '0;
      sync_q   <= '0;
      sig_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      busy_q   <= 1'b0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      target_q <= 1'b0;
    end else begin
      meta_q   <= sig_i;
      sync_q   <= meta_q;
      sig_q    <= sig_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign sig_o        = sig_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign busy_o       = busy_q;
  assign active_idx_o = idx_q;

endmodule

// File: doc/shared_debounce_ctrl.md
# shared_debounce_ctrl

Time-multiplexed debounce controller that shares one debounce timer across `NUM_INPUTS` raw switch/button inputs. It grants the timer round-robin to whichever synchronized input disagrees with its debounced level, commits the new level once the input has been stable for the full debounce period, and emits one-cycle rise/fall event pulses. It sits between the board pushbuttons/switches and the control logic, replacing one `debounce` instance per input.

## Interface

Parameters:
- `NUM_INPUTS`, 4: number of raw inputs, ≥1.
- `CLK_PERIOD_ns`, 20: clock period in ns.
- `DEBOUNCE_TIMER_ns`, 200: required stable time in ns, ≥ `CLK_PERIOD_ns`.
- Derived: `T = DEBOUNCE_TIMER_ns / CLK_PERIOD_ns` (truncating); `IDX_W = max(1, clog2(NUM_INPUTS))`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `enable`  in  1  high = run; low = freeze FSM and timer.
- `sig_i`  in  NUM_INPUTS  raw asynchronous inputs.
- `sig_o`  out  NUM_INPUTS  debounced levels.
- `rise_o`  out  NUM_INPUTS  one-cycle pulse when `sig_o[k]` commits 0→1.
- `fall_o`  out  NUM_INPUTS  one-cycle pulse when `sig_o[k]` commits 1→0.
- `busy_o`  out  1  timer granted (state COUNT).
- `active_idx_o`  out  IDX_W  index currently owning the timer; valid while `busy_o`.

## Operation

- Each `sig_i[k]` passes through a 2-flop synchronizer, giving `sync[k]`. Synchronizers run regardless of `enable`.
- `pending = sync ^ sig_o`.
- FSM states: IDLE, COUNT.
- IDLE, `enable` high, `pending` ≠ 0: grant the first set bit of `pending`, searching upward from round-robin pointer `ptr` with wrap. Latch `idx`, `target = sync[idx]`, `cnt = 0`, go to COUNT.
- COUNT, `enable` high:
  - `sync[idx] != target`: abort (bounce). `ptr = idx+1` mod `NUM_INPUTS`, go to IDLE, no pulses.
  - Otherwise, `cnt == T-1`: commit. `sig_o[idx] = target`, pulse `rise_o[idx]` or `fall_o[idx]`, `ptr = idx+1` mod N, go to IDLE.
  - Otherwise: `cnt++`.
- `enable` low: state, `cnt`, `idx`, `ptr`, and `sig_o` hold. `rise_o` and `fall_o` are 0.
- An input that toggles twice while waiting (net no change) drops out of `pending` and is never granted.
- Reset (`resetn` low at an edge): state IDLE; `ptr`, `cnt`, `idx`, synchronizers, `sig_o`, `rise_o`, `fall_o`, `busy_o`, and `active_idx_o` are all 0. Reset mid-COUNT discards the count and emits no pulse.

## Timing

- Reset value of every output: 0.
- Single input, timer free: `sig_i[k]` changes before edge S0 → `sync[k]` valid at S1 → grant at S2 → commit at edge S2+T. With `T=10`, `sig_o[k]` and the pulse appear at S0+12.
- `rise_o` and `fall_o` are registered, high for exactly the commit cycle, and asserted on the same edge `sig_o` changes.
- Back-to-back service: IDLE lasts exactly one cycle between an abort or commit and the next grant. A second pending input commits T+1 cycles after the first.
- Simultaneous pending inputs: served in round-robin order from `ptr`. At most one commit per T+1 cycles. Worst-case extra wait is `(NUM_INPUTS-1)·(T+1)`.
- `busy_o` rises on the grant edge and falls on the commit or abort edge.
- An `enable`-low span of n cycles during COUNT delays the commit by exactly n cycles.
- `cnt` width is `clog2(T+1)`. It never exceeds T-1.

## Test plan

All scenarios use `NUM_INPUTS=4`, `CLK_PERIOD_ns=20`, `DEBOUNCE_TIMER_ns=200`, so `T=10`.

- Reset: `resetn` low 2 cycles with `sig_i=4'hF` → all outputs 0 during reset and on the first edge after release.
- Clean press/release: `sig_i[0]` 0→1 before edge S0 → `sig_o[0]=1` and `rise_o[0]` high for one cycle at S0+12; `busy_o` high from S0+2 to S0+12. Release 0 later → `fall_o[0]` at the same +12 offset.
- Bounce: `sig_i[1]` high 3 cycles, low 1, then high steady → abort with no pulse; final `rise_o[1]` occurs 12 cycles after the last edge of the bounce.
- Contention: `sig_i[2]` and `sig_i[3]` rise together before S0 with `ptr=0` → `rise_o[2]` at S0+12, `rise_o[3]` at S0+23; never both in one cycle.
- Enable freeze: `sig_i[0]` rises, `enable` low for 5 cycles starting S0+6 → commit at S0+17; `sig_o` is unchanged and no pulses occur while `enable` is low.
- Reset mid-count: `resetn` low at S0+7 with `sig_i[0]` held high, released (sampled high) at edge R → no pulse at S0+12; `rise_o[0]` at R+12.
